alu_issue_queue: RTL
====================

# alu_issue_queue

In-order-age issue queue and scheduler for the backend ALU. Holds up to DEPTH dispatched ALU/branch ops, captures missing source operands from the writeback broadcast, and each cycle issues the oldest op with both operands ready to the ALU. It sits between rename/dispatch and the ALU, driving the ALU's `alu_en`, `opcode`, `val1` and `val2` inputs and the immediate/PC values the ALU consumes.

## Interface
- DEPTH, 4: number of queue entries (2..8).
- TAG_W, 6: width of physical destination/source tags.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  discard all entries (mispredict recovery).
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  queue can accept this cycle.
- disp_opcode  in  instr_opcode  op to queue.
- disp_dst_tag  in  TAG_W  destination tag.
- disp_src1_tag, disp_src2_tag  in  TAG_W  source tags.
- disp_src1_rdy, disp_src2_rdy  in  1  source value already valid.
- disp_src1_val, disp_src2_val  in  32  source values; meaningful when rdy.
- disp_imm  in  32  sign-extended immediate.
- disp_pc  in  32  instruction PC.
- wb_valid  in  1  writeback broadcast valid.
- wb_tag  in  TAG_W  broadcast tag.
- wb_val  in  32  broadcast value.
- alu_stall  in  1  ALU result path busy; no issue this cycle.
- alu_en  out  1  issue strobe to ALU.
- alu_opcode  out  instr_opcode  issued op.
- alu_val1, alu_val2  out  32  issued operands.
- alu_imm, alu_pc  out  32  issued immediate and PC.
- alu_dst_tag  out  TAG_W  issued destination tag.

## Operation
- Collapsing queue: entry 0 is oldest. Each entry holds valid, opcode, dst tag, per-source {tag, rdy, val}, imm, pc.
- Wakeup: when `wb_valid` is high, every valid entry whose source has rdy=0 and a tag equal to `wb_tag` sets rdy=1 and captures `wb_val`. Both sources of one entry may wake in the same cycle.
- Dispatch bypass: a source dispatched with rdy=0 whose tag matches a same-cycle `wb_tag` is written with rdy=1 and `wb_val`.
- Select: the lowest-index entry with valid and both rdy, evaluated on current register state. No issue when `alu_stall` is high.
- Issue: the selected entry is removed, and entries above it shift down one position. The new dispatch is written at the first free slot after the shift.
- `disp_ready` = count < DEPTH. It is combinational from count only; there is no same-cycle credit from issue.
- `disp_valid` while `disp_ready`=0 is ignored.
- Flush has priority over dispatch, wakeup and issue. Next cycle: count=0 and alu_en=0.
- rst has the same effect as flush and additionally zeroes all alu_* outputs.

## Timing
- Reset values: disp_ready=1; alu_en=0; alu_opcode, alu_val1, alu_val2, alu_imm, alu_pc and alu_dst_tag all 0; all entries invalid.
- alu_* outputs are registered. An entry selected in cycle t drives alu_en=1 in cycle t+1 for exactly one cycle. All other alu_* outputs hold their last value while alu_en=0.
- Minimum latency, fully-ready dispatch: dispatched at edge t, selected in t+1, alu_en high in t+2.
- Wakeup latency: a broadcast in cycle t makes the entry selectable in t+1. The queue does not issue an entry in the same cycle as its wakeup.
- Simultaneous dispatch and issue: count is unchanged.
- When full, disp_ready stays 0 in the issue cycle and returns to 1 the cycle after.
- `alu_stall` in cycle t suppresses selection in t only. alu_en(t+1)=0, and no entry is removed.
- Wakeups continue during stall and flush-free cycles.

## Structure
- Shared backend package: add `iq_entry_t` (packed struct of the entry fields) next to `instr_opcode`.
- Sub-module `alu_iq_pick`: parameterised priority picker. Input is a DEPTH-bit ready vector; outputs are a one-hot grant and a valid flag, lowest index wins.
- Queue storage, wakeup compare, collapse shift and output registers live in `alu_issue_queue`.

## Test plan
- Ready dispatch: after reset, dispatch ADD_I with src1=5 and src2=7, both rdy, in cycle 1 → alu_en=1 in cycle 3 with alu_val1=5, alu_val2=7 and alu_opcode=ADD_I; count returns to 0.
- Wakeup ordering:
  - Dispatch entry A (src2 tag 9, not rdy), then fully-ready entry B.
  - B issues first.
  - Broadcast wb_tag=9, wb_val=0x10 → A issues two cycles later with alu_val2=0x10.
- Dispatch bypass: dispatch an op whose src1 tag 3 is not rdy in the same cycle as wb_tag=3, wb_val=0xAA → it issues without waiting, with alu_val1=0xAA.
- Full and back-pressure:
  - Fill 4 entries that are not ready → disp_ready=0, and an extra disp_valid is dropped.
  - Wake entry 2 → it issues, the remaining entries keep their age order, and disp_ready=1 the cycle after issue.
- Stall: hold alu_stall high for 3 cycles with 2 ready entries → alu_en=0 throughout; on release the oldest issues first, then the next on the following cycle.
- Flush and reset mid-operation: with 3 entries valid, assert flush together with disp_valid → next cycle count=0, alu_en=0, nothing issues afterwards. Repeat with rst → the alu_* outputs are also zero.

Source files
------------

// File: rtl/alu_issue_queue_pkg.sv
// -----------------------------------------------------------------------------
// alu_issue_queue_pkg
// Shared backend types for the ALU issue queue.
//   instr_opcode : ALU/branch operation encoding carried from dispatch to ALU.
//   iq_entry_t   : one issue-queue slot (valid, opcode, dst tag, two sources
//                  each with {tag, rdy, val}, immediate, PC).
//   entry_ready  : helper, entry holds a valid op with both operands present.
//   wake_entry   : helper, applies one writeback broadcast to an entry.
// Tags are stored at IQ_TAG_MAX_W bits so the struct is independent of the
// queue's TAG_W parameter; narrower tags are zero-extended on entry.
// -----------------------------------------------------------------------------
package alu_issue_queue_pkg;

    localparam int IQ_TAG_MAX_W = 16;

    typedef enum logic [3:0] {
        ADD_I  = 4'h0,
        SUB_I  = 4'h1,
        AND_I  = 4'h2,
        OR_I   = 4'h3,
        XOR_I  = 4'h4,
        SLL_I  = 4'h5,
        SRL_I  = 4'h6,
        SRA_I  = 4'h7,
        SLT_I  = 4'h8,
        SLTU_I = 4'h9,
        BEQ_I  = 4'hA,
        BNE_I  = 4'hB,
        BLT_I  = 4'hC,
        BGE_I  = 4'hD,
        JAL_I  = 4'hE,
        JALR_I = 4'hF
    } instr_opcode;

    typedef struct packed {
        logic                    valid;
        instr_opcode             opcode;
        logic [IQ_TAG_MAX_W-1:0] dst_tag;
        logic [IQ_TAG_MAX_W-1:0] src1_tag;
        logic                    src1_rdy;
        logic [31:0]             src1_val;
        logic [IQ_TAG_MAX_W-1:0] src2_tag;
        logic                    src2_rdy;
        logic [31:0]             src2_val;
        logic [31:0]             imm;
        logic [31:0]             pc;
    } iq_entry_t;

    function automatic logic entry_ready(input iq_entry_t e);
        return e.valid && e.src1_rdy && e.src2_rdy;
    endfunction

    // Only sources still waiting are updated, so a value that was already
    // captured is never overwritten by a later broadcast of the same tag.
    function automatic iq_entry_t wake_entry(
        input iq_entry_t               e,
        input logic                    wb_v,
        input logic [IQ_TAG_MAX_W-1:0] tag,
        input logic [31:0]             val
    );
        iq_entry_t r;
        r = e;
        if (wb_v && e.valid && !e.src1_rdy && (e.src1_tag == tag)) begin
            r.src1_rdy = 1'b1;
            r.src1_val = val;
        end
        if (wb_v && e.valid && !e.src2_rdy && (e.src2_tag == tag)) begin
            r.src2_rdy = 1'b1;
            r.src2_val = val;
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_iq_pick.sv
// -----------------------------------------------------------------------------
// alu_iq_pick
// Fixed-priority picker: lowest set index of the ready vector wins.
//   rdy_i   [DEPTH] request vector (bit 0 = oldest entry)
//   gnt_o   [DEPTH] one-hot grant, all zero when nothing is requested
//   valid_o         at least one request present
// -----------------------------------------------------------------------------
module alu_iq_pick #(
    parameter int DEPTH = 4
) (
    input  logic [DEPTH-1:0] rdy_i,
    output logic [DEPTH-1:0] gnt_o,
    output logic             valid_o
);

    // x & -x isolates the lowest set bit.
    assign gnt_o   = rdy_i & (~rdy_i + DEPTH'(1));
    assign valid_o = |rdy_i;

endmodule

// File: rtl/alu_issue_queue.sv
// -----------------------------------------------------------------------------
// alu_issue_queue
// Collapsing, age-ordered issue queue for the backend ALU. Entry 0 is the
// oldest. Each cycle the oldest entry with both operands ready (judged on
// registered state) is sent to the ALU through registered outputs; entries
// above it shift down and a new dispatch lands in the first free slot.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush             drop every entry and suppress the pending issue
//   disp_*            dispatch request / ready handshake and op payload
//   wb_valid/tag/val  writeback broadcast used to wake waiting sources
//   alu_stall         suppress selection this cycle
//   alu_*             registered issue strobe and operands to the ALU
// DEPTH 2..8, TAG_W up to IQ_TAG_MAX_W.
// -----------------------------------------------------------------------------
module alu_issue_queue
    import alu_issue_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              disp_valid,
    output logic              disp_ready,
    input  instr_opcode       disp_opcode,
    input  logic [TAG_W-1:0]  disp_dst_tag,
    input  logic [TAG_W-1:0]  disp_src1_tag,
    input  logic [TAG_W-1:0]  disp_src2_tag,
    input  logic              disp_src1_rdy,
    input  logic              disp_src2_rdy,
    input  logic [31:0]       disp_src1_val,
    input  logic [31:0]       disp_src2_val,
    input  logic [31:0]       disp_imm,
    input  logic [31:0]       disp_pc,
    input  logic              wb_valid,
    input  logic [TAG_W-1:0]  wb_tag,
    input  logic [31:0]       wb_val,
    input  logic              alu_stall,
    output logic              alu_en,
    output instr_opcode       alu_opcode,
    output logic [31:0]       alu_val1,
    output logic [31:0]       alu_val2,
    output logic [31:0]       alu_imm,
    output logic [31:0]       alu_pc,
    output logic [TAG_W-1:0]  alu_dst_tag
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    iq_entry_t               entries_q [DEPTH];
    iq_entry_t               entries_d [DEPTH];
    iq_entry_t               woken     [DEPTH];
    iq_entry_t               upper     [DEPTH];
    iq_entry_t               disp_raw;
    iq_entry_t               disp_entry;
    logic [CNT_W-1:0]        count_q;
    logic [CNT_W-1:0]        count_d;
    logic [CNT_W-1:0]        count_after;
    logic [DEPTH-1:0]        rdy_vec;
    logic [DEPTH-1:0]        gnt;
    logic                    issue;
    logic [IDX_W-1:0]        issue_idx;
    logic                    disp_fire;
    logic [IQ_TAG_MAX_W-1:0] wb_tag_ext;

    logic                    alu_en_q;
    instr_opcode             alu_opcode_q;
    logic [31:0]             alu_val1_q;
    logic [31:0]             alu_val2_q;
    logic [31:0]             alu_imm_q;
    logic [31:0]             alu_pc_q;
    logic [TAG_W-1:0]        alu_dst_tag_q;

    assign wb_tag_ext = IQ_TAG_MAX_W'(wb_tag);
    assign disp_ready = (count_q < CNT_W'(DEPTH));
    assign disp_fire  = disp_valid && disp_ready;

    // Per-entry wakeup, ready request and shifted-down view of the slot above.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        assign woken[gi]   = wake_entry(entries_q[gi], wb_valid, wb_tag_ext, wb_val);
        assign rdy_vec[gi] = entry_ready(entries_q[gi]) && !alu_stall;
        if (gi < DEPTH - 1) begin : g_up
            assign upper[gi] = woken[gi + 1];
        end else begin : g_top
            assign upper[gi] = '0;
        end
    end

    alu_iq_pick #(
        .DEPTH (DEPTH)
    ) u_pick (
        .rdy_i   (rdy_vec),
        .gnt_o   (gnt),
        .valid_o (issue)
    );

    always_comb begin
        issue_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (gnt[i]) begin
                issue_idx = IDX_W'(i);
            end
        end
    end

    // The incoming op goes through the same wakeup as stored entries, which
    // gives the same-cycle bypass for a source whose producer is broadcasting.
    always_comb begin
        disp_raw          = '0;
        disp_raw.valid    = 1'b1;
        disp_raw.opcode   = disp_opcode;
        disp_raw.dst_tag  = IQ_TAG_MAX_W'(disp_dst_tag);
        disp_raw.src1_tag = IQ_TAG_MAX_W'(disp_src1_tag);
        disp_raw.src1_rdy = disp_src1_rdy;
        disp_raw.src1_val = disp_src1_val;
        disp_raw.src2_tag = IQ_TAG_MAX_W'(disp_src2_tag);
        disp_raw.src2_rdy = disp_src2_rdy;
        disp_raw.src2_val = disp_src2_val;
        disp_raw.imm      = disp_imm;
        disp_raw.pc       = disp_pc;
    end

    assign disp_entry = wake_entry(disp_raw, wb_valid, wb_tag_ext, wb_val);

    // Collapse above the issued slot, then append the dispatch at the new tail.
    always_comb begin
        count_after = count_q - CNT_W'(issue);
        for (int i = 0; i < DEPTH; i++) begin
            entries_d[i] = woken[i];
            if (issue && (i >= int'(issue_idx))) begin
                entries_d[i] = upper[i];
            end
            if (disp_fire && (CNT_W'(i) == count_after)) begin
                entries_d[i] = disp_entry;
            end
        end
        count_d = count_after + CNT_W'(disp_fire);
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= entries_d[i];
            end
            count_q <= count_d;
        end
    end

    // Payload registers only load on issue so they hold while alu_en is low;
    // flush kills the strobe but leaves the last payload in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_en_q      <= 1'b0;
            alu_opcode_q  <= ADD_I;
            alu_val1_q    <= '0;
            alu_val2_q    <= '0;
            alu_imm_q     <= '0;
            alu_pc_q      <= '0;
            alu_dst_tag_q <= '0;
        end else if (flush) begin
            alu_en_q <= 1'b0;
        end else begin
            alu_en_q <= issue;
            for (int i = 0; i < DEPTH; i++) begin
                if (gnt[i]) begin
                    alu_opcode_q  <= entries_q[i].opcode;
                    alu_val1_q    <= entries_q[i].src1_val;
                    alu_val2_q    <= entries_q[i].src2_val;
                    alu_imm_q     <= entries_q[i].imm;
                    alu_pc_q      <= entries_q[i].pc;
                    alu_dst_tag_q <= TAG_W'(entries_q[i].dst_tag);
                end
            end
        end
    end

    assign alu_en      = alu_en_q;
    assign alu_opcode  = alu_opcode_q;
    assign alu_val1    = alu_val1_q;
    assign alu_val2    = alu_val2_q;
    assign alu_imm     = alu_imm_q;
    assign alu_pc      = alu_pc_q;
    assign alu_dst_tag = alu_dst_tag_q;

endmodule
